// File: rtl/mips_gshare_predictor.sv
// Fetch-stage branch predictor: gshare direction table, tagged direct-mapped BTB and a
// return-address stack. Predicts combinationally; history is speculative and repaired from EX.
module mips_gshare_predictor #(
    parameter int unsigned PHT_IDX_W = 12,
    parameter int unsigned GHR_W     = 8,
    parameter int unsigned BTB_IDX_W = 6,
    parameter int unsigned RAS_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_valid,
    input  logic [29:0]       fetch_pc,
    input  logic              fetch_is_cond,
    input  logic              fetch_is_jump,
    input  logic              fetch_is_call,
    input  logic              fetch_is_ret,
    output logic              pred_taken,
    output logic [29:0]       pred_target,
    output logic [GHR_W-1:0]  pred_ghr,
    input  logic              res_valid,
    input  logic [29:0]       res_pc,
    input  logic              res_is_cond,
    input  logic              res_is_ret,
    input  logic              res_taken,
    input  logic [29:0]       res_target,
    input  logic              res_mispredict,
    input  logic [GHR_W-1:0]  res_ghr
);

    localparam int unsigned PHT_N     = 1 << PHT_IDX_W;
    localparam int unsigned BTB_N     = 1 << BTB_IDX_W;
    localparam int unsigned TAG_W     = 30 - BTB_IDX_W;
    localparam int unsigned RAS_PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned RAS_CNT_W = RAS_PTR_W + 1;

    logic [GHR_W-1:0]     ghr;
    logic [1:0]           pht [PHT_N];
    logic [BTB_N-1:0]     btb_valid;
    logic [TAG_W-1:0]     btb_tag  [BTB_N];
    logic [29:0]          btb_data [BTB_N];
    logic [29:0]          ras      [RAS_DEPTH];
    logic [RAS_PTR_W-1:0] ras_ptr;
    logic [RAS_CNT_W-1:0] ras_cnt;

    logic [PHT_IDX_W-1:0] fetch_pht_idx;
    logic [PHT_IDX_W-1:0] res_pht_idx;
    logic [BTB_IDX_W-1:0] fetch_btb_idx;
    logic [BTB_IDX_W-1:0] res_btb_idx;
    logic                 btb_hit;
    logic [RAS_PTR_W-1:0] ras_top_ptr;
    logic                 ras_nonempty;
    logic [29:0]          pc_plus1;
    logic [29:0]          pc_plus2;
    logic                 ras_push;
    logic                 ras_pop;

    assign fetch_pht_idx = fetch_pc[PHT_IDX_W-1:0] ^ PHT_IDX_W'(ghr);
    assign res_pht_idx   = res_pc[PHT_IDX_W-1:0] ^ PHT_IDX_W'(res_ghr);
    assign fetch_btb_idx = fetch_pc[BTB_IDX_W-1:0];
    assign res_btb_idx   = res_pc[BTB_IDX_W-1:0];
    assign btb_hit       = btb_valid[fetch_btb_idx] &&
                           (btb_tag[fetch_btb_idx] == fetch_pc[29:BTB_IDX_W]);
    assign ras_top_ptr   = ras_ptr - RAS_PTR_W'(1);
    assign ras_nonempty  = (ras_cnt != '0);
    assign pc_plus1      = fetch_pc + 30'd1;
    assign pc_plus2      = fetch_pc + 30'd2;
    assign ras_push      = fetch_valid && fetch_is_call;
    assign ras_pop       = fetch_valid && fetch_is_ret && ras_nonempty;
    assign pred_ghr      = ghr;

    always_comb begin
        pred_taken  = 1'b0;
        pred_target = btb_data[fetch_btb_idx];
        if (fetch_valid) begin
            if (fetch_is_ret && ras_nonempty) begin
                pred_taken  = 1'b1;
                pred_target = ras[ras_top_ptr];
            end else if (fetch_is_jump || fetch_is_ret) begin
                pred_taken = btb_hit;
            end else if (fetch_is_cond) begin
                pred_taken = pht[fetch_pht_idx][1] && btb_hit;
            end
        end
        if (!pred_taken) begin
            pred_target = pc_plus1;
        end
    end

    // EX repair overrides the speculative shift from a same-cycle fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr <= '0;
        end else if (res_valid && res_mispredict) begin
            if (res_is_cond) begin
                ghr <= {res_ghr[GHR_W-2:0], res_taken};
            end else begin
                ghr <= res_ghr;
            end
        end else if (fetch_valid && fetch_is_cond) begin
            ghr <= {ghr[GHR_W-2:0], pred_taken};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PHT_N; i++) begin
                pht[i] <= 2'b01;
            end
        end else if (res_valid && res_is_cond) begin
            if (res_taken && (pht[res_pht_idx] != 2'b11)) begin
                pht[res_pht_idx] <= pht[res_pht_idx] + 2'b01;
            end else if (!res_taken && (pht[res_pht_idx] != 2'b00)) begin
                pht[res_pht_idx] <= pht[res_pht_idx] - 2'b01;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btb_valid <= '0;
        end else if (res_valid && res_taken && !res_is_ret) begin
            btb_valid[res_btb_idx] <= 1'b1;
        end
    end

    // Tag/data need no reset: the valid bits gate every hit.
    always_ff @(posedge clk) begin
        if (res_valid && res_taken && !res_is_ret) begin
            btb_tag[res_btb_idx]  <= res_pc[29:BTB_IDX_W];
            btb_data[res_btb_idx] <= res_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
        end else if (ras_pop && !ras_push) begin
            ras_ptr <= ras_top_ptr;
            ras_cnt <= ras_cnt - RAS_CNT_W'(1);
        end else if (ras_push && !ras_pop) begin
            ras_ptr <= ras_ptr + RAS_PTR_W'(1);
            if (ras_cnt != RAS_CNT_W'(RAS_DEPTH)) begin
                ras_cnt <= ras_cnt + RAS_CNT_W'(1);
            end
        end
    end

    // Pop-then-push collapses to overwriting the current top in place.
    always_ff @(posedge clk) begin
        if (ras_push) begin
            if (ras_pop) begin
                ras[ras_top_ptr] <= pc_plus2;
            end else begin
                ras[ras_ptr] <= pc_plus2;
            end
        end
    end

endmodule

// File: tb/tb_mips_gshare_predictor.sv
// Directed self-checking bench for mips_gshare_predictor: gshare training, GHR repair,
// RAS overflow/underflow, same-cycle BTB write, async reset.
module tb_mips_gshare_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_valid;
    logic [29:0] fetch_pc;
    logic        fetch_is_cond;
    logic        fetch_is_jump;
    logic        fetch_is_call;
    logic        fetch_is_ret;
    logic        pred_taken;
    logic [29:0] pred_target;
    logic [7:0]  pred_ghr;
    logic        res_valid;
    logic [29:0] res_pc;
    logic        res_is_cond;
    logic        res_is_ret;
    logic        res_taken;
    logic [29:0] res_target;
    logic        res_mispredict;
    logic [7:0]  res_ghr;

    int errors = 0;
    int checks = 0;

    mips_gshare_predictor #(
        .PHT_IDX_W(12),
        .GHR_W    (8),
        .BTB_IDX_W(6),
        .RAS_DEPTH(8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_valid   (fetch_valid),
        .fetch_pc      (fetch_pc),
        .fetch_is_cond (fetch_is_cond),
        .fetch_is_jump (fetch_is_jump),
        .fetch_is_call (fetch_is_call),
        .fetch_is_ret  (fetch_is_ret),
        .pred_taken    (pred_taken),
        .pred_target   (pred_target),
        .pred_ghr      (pred_ghr),
        .res_valid     (res_valid),
        .res_pc        (res_pc),
        .res_is_cond   (res_is_cond),
        .res_is_ret    (res_is_ret),
        .res_taken     (res_taken),
        .res_target    (res_target),
        .res_mispredict(res_mispredict),
        .res_ghr       (res_ghr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_fetch();
        fetch_valid   = 1'b0;
        fetch_pc      = '0;
        fetch_is_cond = 1'b0;
        fetch_is_jump = 1'b0;
        fetch_is_call = 1'b0;
        fetch_is_ret  = 1'b0;
    endtask

    task automatic clear_res();
        res_valid      = 1'b0;
        res_pc         = '0;
        res_is_cond    = 1'b0;
        res_is_ret     = 1'b0;
        res_taken      = 1'b0;
        res_target     = '0;
        res_mispredict = 1'b0;
        res_ghr        = '0;
    endtask

    task automatic fetch(input logic [29:0] pc, input logic c, input logic j,
                         input logic call, input logic ret);
        fetch_valid   = 1'b1;
        fetch_pc      = pc;
        fetch_is_cond = c;
        fetch_is_jump = j;
        fetch_is_call = call;
        fetch_is_ret  = ret;
        #1;
    endtask

    task automatic resolve(input logic [29:0] pc, input logic c, input logic taken,
                           input logic [29:0] tgt, input logic misp, input logic [7:0] g);
        res_valid      = 1'b1;
        res_pc         = pc;
        res_is_cond    = c;
        res_is_ret     = 1'b0;
        res_taken      = taken;
        res_target     = tgt;
        res_mispredict = misp;
        res_ghr        = g;
    endtask

    task automatic look(input string tag, input logic [29:0] pc, input logic c,
                        input logic ret, input logic exp_t, input logic [29:0] exp_tgt);
        fetch(pc, c, 1'b0, 1'b0, ret);
        chk({tag, "_taken"}, 32'(pred_taken), 32'(exp_t));
        chk({tag, "_target"}, 32'(pred_target), 32'(exp_tgt));
        clear_fetch();
    endtask

    initial begin
        logic [7:0] exp_ghr [3];
        exp_ghr[0] = 8'h00;
        exp_ghr[1] = 8'h01;
        exp_ghr[2] = 8'h03;

        clear_fetch();
        clear_res();
        rst = 1'b1;
        fetch(30'h100, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_taken", 32'(pred_taken), 32'd0);
        chk("rst_ghr", 32'(pred_ghr), 32'd0);
        clear_fetch();
        tick();
        rst = 1'b0;
        #1;

        fetch(30'h100, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("first_ghr", 32'(pred_ghr), 32'd0);
        clear_fetch();
        look("first", 30'h100, 1'b1, 1'b0, 1'b0, 30'h101);

        // Two taken resolves: counter 01 -> 11, BTB filled.
        resolve(30'h100, 1'b1, 1'b1, 30'h200, 1'b0, 8'h00);
        tick();
        tick();
        clear_res();
        look("trained", 30'h100, 1'b1, 1'b0, 1'b1, 30'h200);

        repeat (4) begin
            resolve(30'h100, 1'b1, 1'b1, 30'h200, 1'b0, 8'h00);
            tick();
        end
        resolve(30'h100, 1'b1, 1'b0, 30'h200, 1'b0, 8'h00);
        tick();
        clear_res();
        look("sat_nt1", 30'h100, 1'b1, 1'b0, 1'b1, 30'h200);
        resolve(30'h100, 1'b1, 1'b0, 30'h200, 1'b0, 8'h00);
        tick();
        clear_res();
        look("sat_nt2", 30'h100, 1'b1, 1'b0, 1'b0, 30'h101);

        // Retrain idx 0x100 and pretrain 0x101, 0x103 so three fetches at 0x100 predict taken.
        for (int g = 0; g < 3; g++) begin
            repeat (2) begin
                resolve(30'h100, 1'b1, 1'b1, 30'h200, 1'b0, exp_ghr[g]);
                tick();
            end
        end
        clear_res();
        for (int k = 0; k < 3; k++) begin
            fetch(30'h100, 1'b1, 1'b0, 1'b0, 1'b0);
            chk("ghr_fetch_taken", 32'(pred_taken), 32'd1);
            chk("ghr_fetch_ghr", 32'(pred_ghr), 32'(exp_ghr[k]));
            tick();
        end
        chk("ghr_after3", 32'(pred_ghr), 32'h07);
        chk("ghr_idx107_taken", 32'(pred_taken), 32'd0);
        resolve(30'h100, 1'b1, 1'b0, 30'h200, 1'b1, 8'h01);
        tick();
        clear_res();
        clear_fetch();
        #1;
        chk("ghr_repair_cond", 32'(pred_ghr), 32'h02);
        fetch(30'h100, 1'b1, 1'b0, 1'b0, 1'b0);
        resolve(30'h300, 1'b0, 1'b0, 30'h0, 1'b1, 8'h55);
        tick();
        clear_res();
        clear_fetch();
        #1;
        chk("ghr_repair_jump", 32'(pred_ghr), 32'h55);
        resolve(30'h300, 1'b0, 1'b0, 30'h0, 1'b1, 8'h00);
        tick();
        clear_res();

        look("wrap_plus1", 30'h3FFFFFFF, 1'b0, 1'b0, 1'b0, 30'h0);

        fetch(30'h40, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        clear_fetch();
        fetch(30'h80, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ras_one_taken", 32'(pred_taken), 32'd1);
        chk("ras_one_target", 32'(pred_target), 32'h42);
        tick();
        clear_fetch();

        for (int i = 0; i < 9; i++) begin
            fetch(30'h1000 + 30'(i * 16), 1'b0, 1'b0, 1'b1, 1'b0);
            tick();
        end
        for (int i = 8; i >= 1; i--) begin
            fetch(30'h80, 1'b0, 1'b0, 1'b0, 1'b1);
            chk("ras_ovf_taken", 32'(pred_taken), 32'd1);
            chk("ras_ovf_target", 32'(pred_target), 32'h1002 + 32'(i * 16));
            tick();
        end
        clear_fetch();
        look("ras_empty", 30'h80, 1'b0, 1'b1, 1'b0, 30'h81);

        // BTB write and lookup on the same index in the same cycle.
        fetch(30'h80, 1'b0, 1'b0, 1'b0, 1'b1);
        resolve(30'h80, 1'b0, 1'b1, 30'h300, 1'b0, 8'h00);
        chk("btb_same_cycle", 32'(pred_taken), 32'd0);
        tick();
        clear_res();
        #1;
        chk("btb_next_taken", 32'(pred_taken), 32'd1);
        chk("btb_next_target", 32'(pred_target), 32'h300);
        clear_fetch();

        fetch(30'h3FFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        clear_fetch();
        look("ras_wrap", 30'h80, 1'b0, 1'b1, 1'b1, 30'h1);

        fetch(30'h500, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        clear_fetch();
        resolve(30'h300, 1'b0, 1'b0, 30'h0, 1'b1, 8'h55);
        tick();
        clear_res();
        #1;
        chk("pre_rst_ghr", 32'(pred_ghr), 32'h55);
        #2;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        chk("post_rst_ghr", 32'(pred_ghr), 32'd0);
        look("post_rst_ret", 30'h80, 1'b0, 1'b1, 1'b0, 30'h81);
        look("post_rst_cond", 30'h100, 1'b1, 1'b0, 1'b0, 30'h101);
        fetch(30'h80, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("post_rst_jump", 32'(pred_taken), 32'd0);
        clear_fetch();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
